// File: rtl/ysyx_041514_csr_rmw_unit_pkg.sv
// ysyx_041514_csr_rmw_unit_pkg: one-hot op indices, op width, FSM encodings and op sanitiser
package ysyx_041514_csr_rmw_unit_pkg;
  localparam int OP_W = 5;
  localparam int OP_NONE = 0;
  localparam int OP_READ = 1;
  localparam int OP_WRITE = 2;
  localparam int OP_SET = 3;
  localparam int OP_CLEAR = 4;
  localparam logic [OP_W-1:0] OP_NONE_OH = 5'b00001;
  localparam logic [OP_W-1:0] OP_WMASK = 5'b11100;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;
  // anything that is not exactly one-hot degrades to NONE
  function automatic logic [OP_W-1:0] op_sanitize(input logic [OP_W-1:0] op);
    return (op != '0 && (op & (op - 1'b1)) == '0) ? op : OP_NONE_OH;
  endfunction
endpackage

// File: rtl/ysyx_041514_csr_rmw_unit_alu.sv
// ysyx_041514_csr_alu: combinational WRITE/SET/CLEAR data and write-enable generation
module ysyx_041514_csr_alu
  import ysyx_041514_csr_rmw_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] wdata,
  output logic            wen
);
  always_comb begin
    wdata = op[OP_WRITE] ? operand : op[OP_SET] ? (old | operand) : op[OP_CLEAR] ? (old & ~operand) : old;
    wen = |(op & OP_WMASK);
  end
endmodule

// File: rtl/ysyx_041514_csr_rmw_unit.sv
// ysyx_041514_csr_rmw_unit: multi-cycle CSR RMW engine; YSYX_041514_CSR_RO_CHECK_EN enables read-only CSR trapping
module ysyx_041514_csr_rmw_unit
  import ysyx_041514_csr_rmw_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int IMM_LEN = 5,
  parameter int CSR_AW = 12,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [OP_W-1:0]    req_op_i,
  input  logic [CSR_AW-1:0]  req_addr_i,
  input  logic [IMM_LEN-1:0] req_imm_i,
  input  logic               req_imm_valid_i,
  input  logic [XLEN-1:0]    req_rs1_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  output logic               csr_rd_en_o,
  output logic [CSR_AW-1:0]  csr_rd_addr_o,
  input  logic               csr_rd_valid_i,
  input  logic [XLEN-1:0]    csr_rd_data_i,
  output logic               csr_wr_en_o,
  output logic [CSR_AW-1:0]  csr_wr_addr_o,
  output logic [XLEN-1:0]    csr_wr_data_o,
  input  logic               csr_wr_ready_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [XLEN-1:0]    resp_data_o,
  output logic [TAG_W-1:0]   resp_tag_o,
  output logic               resp_illegal_o
);
`ifdef YSYX_041514_CSR_RO_CHECK_EN
  localparam bit RO_CHECK = 1'b1;
`else
  localparam bit RO_CHECK = 1'b0;
`endif
  state_e            state;
  logic [OP_W-1:0]   op_q, req_op_s;
  logic [CSR_AW-1:0] addr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [XLEN-1:0]   opnd_q, old_q, alu_wdata;
  logic              illegal_q, flushed_q, alu_wen, ro_hit;
  assign req_op_s = op_sanitize(req_op_i);
  assign ro_hit = RO_CHECK && alu_wen && (addr_q[CSR_AW-1 -: 2] == 2'b11);
  assign csr_rd_addr_o = addr_q;
  assign csr_wr_addr_o = addr_q;
  assign resp_data_o = old_q;
  assign resp_tag_o = tag_q;
  assign resp_illegal_o = illegal_q;
  ysyx_041514_csr_alu #(.XLEN(XLEN)) u_alu (
    .op(op_q),
    .old(csr_rd_data_i),
    .operand(opnd_q),
    .wdata(alu_wdata),
    .wen(alu_wen)
  );
  // flushed_q remembers a flush seen in WR so the in-flight write finishes without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= '0;
      addr_q <= '0;
      tag_q <= '0;
      opnd_q <= '0;
      old_q <= '0;
      illegal_q <= 1'b0;
      flushed_q <= 1'b0;
      req_ready_o <= 1'b1;
      csr_rd_en_o <= 1'b0;
      csr_wr_en_o <= 1'b0;
      csr_wr_data_o <= '0;
      resp_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid_i && !flush_i) begin
          op_q <= req_op_s;
          addr_q <= req_addr_i;
          tag_q <= req_tag_i;
          opnd_q <= req_imm_valid_i ? XLEN'(req_imm_i) : req_rs1_i;
          old_q <= '0;
          illegal_q <= 1'b0;
          flushed_q <= 1'b0;
          req_ready_o <= 1'b0;
          if (req_op_s[OP_NONE]) begin
            state <= S_RESP;
            resp_valid_o <= 1'b1;
          end else begin
            state <= S_RD;
            csr_rd_en_o <= 1'b1;
          end
        end
        S_RD: if (flush_i) begin
          state <= S_IDLE;
          csr_rd_en_o <= 1'b0;
          req_ready_o <= 1'b1;
        end else if (csr_rd_valid_i) begin
          old_q <= csr_rd_data_i;
          csr_rd_en_o <= 1'b0;
          if (alu_wen && !ro_hit) begin
            state <= S_WR;
            csr_wr_en_o <= 1'b1;
            csr_wr_data_o <= alu_wdata;
          end else begin
            state <= S_RESP;
            resp_valid_o <= 1'b1;
            illegal_q <= ro_hit;
          end
        end
        S_WR: if (csr_wr_ready_i) begin
          csr_wr_en_o <= 1'b0;
          if (flush_i || flushed_q) begin
            state <= S_IDLE;
            req_ready_o <= 1'b1;
          end else begin
            state <= S_RESP;
            resp_valid_o <= 1'b1;
          end
        end else if (flush_i) begin
          flushed_q <= 1'b1;
        end
        S_RESP: if (flush_i || resp_ready_i) begin
          state <= S_IDLE;
          resp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_041514_csr_rmw_unit.sv
// tb_ysyx_041514_csr_rmw_unit: scoreboard bench with a CSR-file responder and a spec-level reference model
module tb_ysyx_041514_csr_rmw_unit;
  localparam int XLEN = 64, IMM_LEN = 5, CSR_AW = 12, TAG_W = 5;
`ifdef YSYX_041514_CSR_RO_CHECK_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o, req_imm_valid_i = 1'b0;
  logic [4:0] req_op_i = '0;
  logic [CSR_AW-1:0] req_addr_i = '0;
  logic [IMM_LEN-1:0] req_imm_i = '0;
  logic [XLEN-1:0] req_rs1_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic csr_rd_en_o, csr_rd_valid_i, csr_wr_en_o, csr_wr_ready_i;
  logic [CSR_AW-1:0] csr_rd_addr_o, csr_wr_addr_o;
  logic [XLEN-1:0] csr_rd_data_i, csr_wr_data_o, resp_data_o;
  logic resp_valid_o, resp_ready_i, resp_illegal_o;
  logic [TAG_W-1:0] resp_tag_o;
  typedef struct {
    logic [XLEN-1:0] data;
    logic [TAG_W-1:0] tag;
    logic ill;
    int lat;
    int acc;
  } resp_t;
  typedef struct {
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0] data;
  } wr_t;
  resp_t resp_q[$];
  wr_t wr_q[$];
  logic [CSR_AW-1:0] rd_q[$];
  logic [XLEN-1:0] csr_file[4096];
  logic [XLEN-1:0] ref_csr[4096];
  int cyc = 0, vectors = 0, miscompares = 0;
  int rd_lat = 0, wr_lat = 0, rr_pct = 100, stall = 0;

  ysyx_041514_csr_rmw_unit #(.XLEN(XLEN), .IMM_LEN(IMM_LEN), .CSR_AW(CSR_AW), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_imm_i(req_imm_i), .req_imm_valid_i(req_imm_valid_i),
    .req_rs1_i(req_rs1_i), .req_tag_i(req_tag_i),
    .csr_rd_en_o(csr_rd_en_o), .csr_rd_addr_o(csr_rd_addr_o),
    .csr_rd_valid_i(csr_rd_valid_i), .csr_rd_data_i(csr_rd_data_i),
    .csr_wr_en_o(csr_wr_en_o), .csr_wr_addr_o(csr_wr_addr_o),
    .csr_wr_data_o(csr_wr_data_o), .csr_wr_ready_i(csr_wr_ready_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .resp_tag_o(resp_tag_o), .resp_illegal_o(resp_illegal_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setcsr(input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] v);
    csr_file[a] = v;
    ref_csr[a] = v;
  endtask

  // mode 0: full transaction, 1: aborted before read completes, 2: write commits but response suppressed
  task automatic issue(input logic [4:0] op, input logic [CSR_AW-1:0] addr, input logic [IMM_LEN-1:0] imm,
                       input logic iv, input logic [XLEN-1:0] rs1, input logic [TAG_W-1:0] tag,
                       input int mode, input int lat);
    int n, kind;
    logic [XLEN-1:0] opnd, old, nv;
    logic wcls, ill;
    n = 0;
    kind = 0;
    @(negedge clk);
    req_op_i = op;
    req_addr_i = addr;
    req_imm_i = imm;
    req_imm_valid_i = iv;
    req_rs1_i = rs1;
    req_tag_i = tag;
    req_valid_i = 1'b1;
    while (!req_ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      check("accept_timeout", 64'(req_ready_o), 64'(1));
      req_valid_i = 1'b0;
      return;
    end
    for (int i = 0; i < 5; i++) if (op == 5'(1 << i)) kind = i;
    opnd = iv ? XLEN'(imm) : rs1;
    old = (kind == 0) ? '0 : ref_csr[addr];
    wcls = kind >= 2;
    ill = RO && wcls && (addr[11:10] == 2'b11);
    nv = (kind == 2) ? opnd : (kind == 3) ? (old | opnd) : (old & ~opnd);
    if (mode != 1) begin
      if (kind != 0) rd_q.push_back(addr);
      if (wcls && !ill) begin
        ref_csr[addr] = nv;
        wr_q.push_back('{addr, nv});
      end
      if (mode == 0) resp_q.push_back('{old, tag, ill, lat, cyc});
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0 || !req_ready_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain_pending", 64'(resp_q.size() + wr_q.size() + rd_q.size()), 64'(0));
    check("drain_idle_ready", 64'(req_ready_o), 64'(1));
  endtask

  // CSR file responder: honours configurable read/write latencies
  initial begin
    int rw, ww;
    wr_t w;
    rw = 0;
    ww = 0;
    csr_rd_valid_i = 1'b0;
    csr_wr_ready_i = 1'b0;
    csr_rd_data_i = '0;
    forever begin
      @(negedge clk);
      csr_rd_valid_i = 1'b0;
      csr_wr_ready_i = 1'b0;
      if (!csr_rd_en_o) rw = rd_lat;
      else if (rw > 0) begin
        rw--;
        if (rd_q.size() != 0) check("rd_addr_hold", 64'(csr_rd_addr_o), 64'(rd_q[0]));
      end else begin
        if (rd_q.size() == 0) check("rd_unexpected", 64'(csr_rd_en_o), 64'(0));
        else check("rd_addr", 64'(csr_rd_addr_o), 64'(rd_q.pop_front()));
        csr_rd_data_i = csr_file[csr_rd_addr_o];
        csr_rd_valid_i = 1'b1;
      end
      if (!csr_wr_en_o) ww = wr_lat;
      else if (ww > 0) ww--;
      else begin
        if (wr_q.size() == 0) check("wr_unexpected", 64'(csr_wr_en_o), 64'(0));
        else begin
          w = wr_q.pop_front();
          check("wr_addr", 64'(csr_wr_addr_o), 64'(w.addr));
          check("wr_data", csr_wr_data_o, w.data);
        end
        csr_file[csr_wr_addr_o] = csr_wr_data_o;
        csr_wr_ready_i = 1'b1;
      end
    end
  end

  // response monitor: drives resp_ready_i and pops the scoreboard on each handshake
  initial begin
    resp_t e;
    logic shown;
    shown = 1'b0;
    resp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (csr_rd_en_o || csr_wr_en_o || resp_valid_o)) check("ready_while_busy", 64'(req_ready_o), 64'(0));
      if (!resp_valid_o) begin
        resp_ready_i = 1'b0;
        shown = 1'b0;
      end else if (resp_q.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid_o), 64'(0));
        resp_ready_i = 1'b1;
      end else begin
        e = resp_q[0];
        if (!shown && e.lat >= 0) check("resp_latency", 64'(cyc - e.acc), 64'(e.lat));
        check("resp_data", resp_data_o, e.data);
        check("resp_tag", 64'(resp_tag_o), 64'(e.tag));
        check("resp_illegal", 64'(resp_illegal_o), 64'(e.ill));
        shown = 1'b1;
        if (stall > 0) begin
          stall--;
          resp_ready_i = 1'b0;
        end else resp_ready_i = ($urandom_range(0, 99) < rr_pct);
        if (resp_ready_i) begin
          void'(resp_q.pop_front());
          shown = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [CSR_AW-1:0] addrs[8];
    logic [XLEN-1:0] v;
    logic [4:0] op;
    int n, k;
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hC00, 12'hF14, 12'hC80, 12'h7C0};
    for (int i = 0; i < 4096; i++) setcsr(12'(i), {$urandom, $urandom});
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'(1));
    check("rst_rd_en", 64'(csr_rd_en_o), 64'(0));
    check("rst_wr_en", 64'(csr_wr_en_o), 64'(0));
    check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("rst_resp_data", resp_data_o, 64'(0));
    check("rst_resp_tag", 64'(resp_tag_o), 64'(0));
    check("rst_illegal", 64'(resp_illegal_o), 64'(0));
    check("rst_wr_data", csr_wr_data_o, 64'(0));
    rst_n = 1'b1;
    setcsr(12'h300, 64'h11);
    issue(5'b00100, 12'h300, 5'h0, 1'b0, 64'hA5, 5'd1, 0, 3);
    drain();
    check("csrrw_file", csr_file[12'h300], 64'hA5);
    setcsr(12'h340, 64'h8);
    issue(5'b01000, 12'h340, 5'h3, 1'b1, {$urandom, $urandom}, 5'd2, 0, 3);
    drain();
    check("csrrsi_file", csr_file[12'h340], 64'hB);
    setcsr(12'h341, 64'hF);
    issue(5'b10000, 12'h341, 5'($urandom), 1'b0, 64'h9, 5'd3, 0, 3);
    drain();
    check("csrrc_file", csr_file[12'h341], 64'h6);
    issue(5'b00010, 12'hF14, 5'h0, 1'b0, {$urandom, $urandom}, 5'd7, 0, 2);
    issue(5'b00001, 12'h300, 5'h1, 1'b0, 64'h5, 5'd8, 0, 1);
    issue(5'b00000, 12'h300, 5'h1, 1'b0, 64'h5, 5'd9, 0, 1);
    issue(5'b00110, 12'h300, 5'h1, 1'b0, 64'h5, 5'd10, 0, 1);
    drain();
    check("multibit_no_write", csr_file[12'h300], 64'hA5);
    rd_lat = 4;
    stall = 3;
    issue(5'b00010, 12'h305, 5'h0, 1'b0, 64'h0, 5'd11, 0, 6);
    rd_lat = 0;
    issue(5'b00100, 12'h305, 5'h1f, 1'b1, 64'h0, 5'd12, 0, 3);
    drain();
    rd_lat = 6;
    issue(5'b00100, 12'h7C0, 5'h0, 1'b0, 64'hDEAD, 5'd13, 1, -1);
    @(negedge clk);
    check("flush_rd_en_before", 64'(csr_rd_en_o), 64'(1));
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_rd_idle", 64'(req_ready_o), 64'(1));
    check("flush_rd_en_after", 64'(csr_rd_en_o), 64'(0));
    rd_lat = 0;
    drain();
    check("flush_rd_no_write", csr_file[12'h7C0], ref_csr[12'h7C0]);
    wr_lat = 4;
    issue(5'b01000, 12'h7C0, 5'h0, 1'b0, 64'hF0F0, 5'd14, 2, -1);
    n = 0;
    while (!csr_wr_en_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("flush_wr_en_seen", 64'(csr_wr_en_o), 64'(1));
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    drain();
    wr_lat = 0;
    check("flush_wr_committed", csr_file[12'h7C0], ref_csr[12'h7C0]);
    @(negedge clk);
    req_op_i = 5'b00010;
    req_addr_i = 12'h300;
    req_tag_i = 5'd15;
    req_valid_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    check("flush_idle_not_accepted", 64'(req_ready_o), 64'(1));
    check("flush_idle_no_rd", 64'(csr_rd_en_o), 64'(0));
    issue(5'b00010, 12'h300, 5'h0, 1'b0, 64'h0, 5'd15, 0, 2);
    drain();
    stall = 100;
    issue(5'b00010, 12'h341, 5'h0, 1'b0, 64'h0, 5'd16, 0, 2);
    n = 0;
    while (!resp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    if (resp_q.size() != 0) void'(resp_q.pop_front());
    stall = 0;
    check("flush_resp_dropped", 64'(resp_valid_o), 64'(0));
    drain();
    rd_lat = 6;
    issue(5'b00100, 12'h305, 5'h0, 1'b0, 64'h1234, 5'd17, 1, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_en", 64'(csr_rd_en_o), 64'(0));
    check("midrst_ready", 64'(req_ready_o), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    rd_lat = 0;
    drain();
    check("midrst_no_write", csr_file[12'h305], ref_csr[12'h305]);
    v = {$urandom, $urandom};
    setcsr(12'hC00, 64'h77);
    issue(5'b00100, 12'hC00, 5'h0, 1'b0, v, 5'd18, 0, RO ? 2 : 3);
    drain();
    check("ro_file", csr_file[12'hC00], RO ? 64'h77 : v);
    rr_pct = 70;
    for (int t = 0; t < 300; t++) begin
      rd_lat = $urandom_range(0, 3);
      wr_lat = $urandom_range(0, 3);
      k = $urandom_range(0, 7);
      op = ($urandom_range(0, 9) < 8) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
      issue(op, (k == 7) ? 12'($urandom) : addrs[3'(k)], 5'($urandom), 1'($urandom), {$urandom, $urandom},
            5'($urandom), 0, -1);
    end
    drain();
    for (int i = 0; i < 8; i++) check("final_file", csr_file[addrs[i]], ref_csr[addrs[i]]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
